// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher: iterative AES-128/192/256 block cipher, one round per cycle,
// round keys fetched through rk_idx/rk_in, results buffered in an output FIFO.
// Define AES_ITER_CIPHER_DEC_EN to compile in the inverse cipher and in_dir handling.
module aes_iter_cipher #(
  parameter int unsigned OUT_DEPTH = 2,
  parameter int unsigned TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [1:0]       in_mode,
  input  logic             in_dir,
  input  logic [TAG_W-1:0] in_tag,
  output logic [3:0]       rk_idx,
  input  logic [127:0]     rk_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(OUT_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

  state_t             state, state_nxt;
  logic [3:0]         rnd;
  logic [127:0]       stm;
  logic [1:0]         mode_q;
  logic               dir_q;
  logic [TAG_W-1:0]   tag_q;
  logic               dir_in;
  logic               is_final;
  logic               push, pop;
  logic [127:0]       enc_sr, enc_out, round_out;
  logic [127:0]       mem_data [OUT_DEPTH];
  logic [TAG_W-1:0]   mem_tag  [OUT_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  function automatic logic [3:0] nr_of(input logic [1:0] m);
    return (m == 2'b00) ? 4'd10 : (m == 2'b01) ? 4'd12 : 4'd14;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse in GF(2^8) as x^254 (maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gmul(x, x);
    x3   = gmul(x2, x);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(gmul(gmul(x15, x15), gmul(x15, x15)), gmul(gmul(x15, x15), gmul(x15, x15)));
    x240 = gmul(x240, x240);
    return gmul(gmul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte b = 4*col + row sits at bits [127-8b -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

`ifdef AES_ITER_CIPHER_DEC_EN
  logic [127:0] dec_t, dec_out;

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9),
            gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13),
            gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11),
            gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14)};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  assign dir_in = in_dir;

  // Inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns except last.
  always_comb begin
    dec_t   = inv_sub_bytes(inv_shift_rows(stm)) ^ rk_in;
    dec_out = is_final ? dec_t : inv_mix_columns(dec_t);
  end

  assign round_out = dir_q ? dec_out : enc_out;
`else
  logic unused_dir;
  assign unused_dir = in_dir;
  assign dir_in     = 1'b0;
  assign round_out  = enc_out;
`endif

  assign is_final  = (state == FINAL);
  assign in_ready  = (state == IDLE) && (count < CNT_W'(OUT_DEPTH));
  assign busy      = (state != IDLE);
  assign out_valid = (count != '0);
  assign out_data  = mem_data[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];
  assign push      = is_final;
  assign pop       = out_valid && out_ready;

  // Forward round: SubBytes, ShiftRows, MixColumns except last, AddRoundKey.
  always_comb begin
    enc_sr  = shift_rows(sub_bytes(stm));
    enc_out = (is_final ? enc_sr : mix_columns(enc_sr)) ^ rk_in;
  end

  // Next-state and round-key index selection.
  always_comb begin
    state_nxt = state;
    rk_idx    = 4'd0;
    case (state)
      IDLE: begin
        rk_idx = dir_in ? nr_of(in_mode) : 4'd0;
        if (in_valid && in_ready) state_nxt = ROUND;
      end
      ROUND: begin
        rk_idx = dir_q ? (nr_of(mode_q) - rnd) : rnd;
        if (rnd == nr_of(mode_q) - 4'd1) state_nxt = FINAL;
      end
      FINAL: begin
        rk_idx    = dir_q ? (nr_of(mode_q) - rnd) : rnd;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Cipher state, round counter and per-block attributes latched at acceptance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stm    <= '0;
      rnd    <= 4'd0;
      mode_q <= 2'b00;
      dir_q  <= 1'b0;
      tag_q  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          stm    <= in_data ^ rk_in;
          rnd    <= 4'd1;
          mode_q <= in_mode;
          dir_q  <= dir_in;
          tag_q  <= in_tag;
        end
        ROUND: begin
          stm <= round_out;
          rnd <= rnd + 4'd1;
        end
        FINAL:   rnd <= 4'd0;
        default: rnd <= 4'd0;
      endcase
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Output FIFO: circular buffer with count; pushes on FINAL, pops on out handshake.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(OUT_DEPTH); i++) begin
        mem_data[i] <= '0;
        mem_tag[i]  <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= round_out;
        mem_tag[wr_ptr]  <= tag_q;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
